// File: rtl/entry_controller_pkg.sv
// ============================================================================
// Module : entry_controller_pkg
// Brief  : Key codes, ALU op encoding and FSM state type for the entry
//          controller slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package entry_controller_pkg;

  localparam logic [3:0] C_KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] C_KEY_ADD       = 4'hA;
  localparam logic [3:0] C_KEY_SUB       = 4'hB;
  localparam logic [3:0] C_KEY_MUL       = 4'hC;
  localparam logic [3:0] C_KEY_DIV       = 4'hD;
  localparam logic [3:0] C_KEY_EQ        = 4'hE;
  localparam logic [3:0] C_KEY_CLR       = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_OP    = 3'd1,
    S_B     = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SHOW  = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= C_KEY_MAX_DIGIT;
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k >= C_KEY_ADD) && (k <= C_KEY_DIV);
  endfunction

  // A..D map onto 00..11; subtracting 2 from the low bits does the remap.
  function automatic op_e key_to_op(input logic [3:0] k);
    return op_e'(k[1:0] - 2'd2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/entry_controller_if.sv
// ============================================================================
// Module : entry_controller_if
// Brief  : Operand/start/done handshake between entry controller and BCD ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface entry_controller_if #(
  parameter int MAX_DIGITS = 4
) ();

  logic [4*MAX_DIGITS-1:0] operand_a;
  logic [4*MAX_DIGITS-1:0] operand_b;
  logic [1:0]              op;
  logic                    alu_start;
  logic                    alu_ready;
  logic                    alu_done;
  logic [4*MAX_DIGITS-1:0] alu_result;

  modport master (
    output operand_a, operand_b, op, alu_start,
    input  alu_ready, alu_done, alu_result
  );

  modport slave (
    input  operand_a, operand_b, op, alu_start,
    output alu_ready, alu_done, alu_result
  );

endinterface

`default_nettype wire

// File: rtl/entry_controller_key_debouncer.sv
// ============================================================================
// Module : key_debouncer
// Brief  : Per-scan-iteration debounce; one key_event per accepted press.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       tick,
  input  wire logic       valid,
  input  wire logic [3:0] key,
  output logic            key_event,
  output logic [3:0]      event_key
);

  localparam int              C_CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [C_CNT_W-1:0] C_SCANS = C_CNT_W'(DEBOUNCE_SCANS);

  logic               r_pressed;
  logic [C_CNT_W-1:0] r_cnt;
  logic [3:0]         r_cand_key;
  logic               r_event;
  logic [C_CNT_W-1:0] w_press_cnt;
  logic [C_CNT_W-1:0] w_rel_cnt;

  // A different key than the candidate restarts the press count at 1.
  always_comb begin
    w_press_cnt = C_CNT_W'(1);
    if ((r_cnt != '0) && (key == r_cand_key))
      w_press_cnt = r_cnt + C_CNT_W'(1);
    w_rel_cnt = r_cnt + C_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pressed  <= 1'b0;
      r_cnt      <= '0;
      r_cand_key <= 4'h0;
      r_event    <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (tick) begin
        if (!r_pressed) begin
          if (valid) begin
            r_cand_key <= key;
            if (w_press_cnt >= C_SCANS) begin
              r_event   <= 1'b1;
              r_pressed <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= w_press_cnt;
            end
          end else begin
            r_cnt <= '0;
          end
        end else begin
          if (!valid) begin
            if (w_rel_cnt >= C_SCANS) begin
              r_pressed <= 1'b0;
              r_cnt     <= '0;
            end else begin
              r_cnt <= w_rel_cnt;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end
    end
  end

  assign key_event = r_event;
  assign event_key = r_cand_key;

endmodule

`default_nettype wire

// File: rtl/entry_controller.sv
// ============================================================================
// Module : entry_controller
// Brief  : Keypad calculator entry FSM driving a BCD ALU handshake.
//          Optional ENTRY_OVERFLOW_ERR_EN adds a sticky digit-overflow error.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module entry_controller
  import entry_controller_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int MAX_DIGITS     = 4
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  input  wire logic                    iteration_tick,
  input  wire logic                    valid_iteration,
  input  wire logic [3:0]              key,
  entry_controller_if.master           alu,
  output logic [4*MAX_DIGITS-1:0]      display,
`ifdef ENTRY_OVERFLOW_ERR_EN
  output logic                         error,
`endif
  output logic                         busy
);

  localparam int                 C_W     = 4 * MAX_DIGITS;
  localparam int                 C_DCW   = $clog2(MAX_DIGITS + 1);
  localparam logic [C_DCW-1:0]   C_MAXD  = C_DCW'(MAX_DIGITS);

  logic             w_key_event;
  logic [3:0]       w_event_key;

  state_e           r_state,   w_state_nx;
  logic [C_W-1:0]   r_opa,     w_opa_nx;
  logic [C_W-1:0]   r_opb,     w_opb_nx;
  op_e              r_op,      w_op_nx;
  logic [C_DCW-1:0] r_cnt_a,   w_cnt_a_nx;
  logic [C_DCW-1:0] r_cnt_b,   w_cnt_b_nx;
  logic [C_W-1:0]   r_display, w_display_nx;
  logic             w_key_ok;
  logic             w_locked;
  logic [C_W-1:0]   w_digit;
`ifdef ENTRY_OVERFLOW_ERR_EN
  logic             r_err, w_err_nx;
`endif

  key_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_key_debouncer (
    .clock     (clock),
    .reset     (reset),
    .tick      (iteration_tick),
    .valid     (valid_iteration),
    .key       (key),
    .key_event (w_key_event),
    .event_key (w_event_key)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_A;
      r_opa     <= '0;
      r_opb     <= '0;
      r_op      <= OP_ADD;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_display <= '0;
`ifdef ENTRY_OVERFLOW_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_opa     <= w_opa_nx;
      r_opb     <= w_opb_nx;
      r_op      <= w_op_nx;
      r_cnt_a   <= w_cnt_a_nx;
      r_cnt_b   <= w_cnt_b_nx;
      r_display <= w_display_nx;
`ifdef ENTRY_OVERFLOW_ERR_EN
      r_err     <= w_err_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_opa_nx     = r_opa;
    w_opb_nx     = r_opb;
    w_op_nx      = r_op;
    w_cnt_a_nx   = r_cnt_a;
    w_cnt_b_nx   = r_cnt_b;
    w_display_nx = r_display;
`ifdef ENTRY_OVERFLOW_ERR_EN
    w_err_nx     = r_err;
    w_locked     = r_err;
`else
    w_locked     = 1'b0;
`endif
    w_digit  = C_W'(w_event_key);
    // A completing ALU result wins over a simultaneous key press.
    w_key_ok = w_key_event && !((r_state == S_WAIT) && alu.alu_done);

    if (w_key_ok && (w_event_key == C_KEY_CLR)) begin
      w_state_nx   = S_A;
      w_opa_nx     = '0;
      w_opb_nx     = '0;
      w_op_nx      = OP_ADD;
      w_cnt_a_nx   = '0;
      w_cnt_b_nx   = '0;
      w_display_nx = '0;
`ifdef ENTRY_OVERFLOW_ERR_EN
      w_err_nx     = 1'b0;
`endif
    end else begin
      case (r_state)
        S_A: begin
          if (w_key_ok && !w_locked) begin
            if (is_digit(w_event_key)) begin
              if (r_cnt_a < C_MAXD) begin
                w_opa_nx   = (r_opa << 4) | w_digit;
                w_cnt_a_nx = r_cnt_a + C_DCW'(1);
              end else begin
`ifdef ENTRY_OVERFLOW_ERR_EN
                w_err_nx = 1'b1;
`endif
              end
            end else if (is_operator(w_event_key)) begin
              w_op_nx    = key_to_op(w_event_key);
              w_state_nx = S_OP;
            end
          end
        end
        S_OP: begin
          if (w_key_ok && !w_locked) begin
            if (is_digit(w_event_key)) begin
              w_opb_nx   = w_digit;
              w_cnt_b_nx = C_DCW'(1);
              w_state_nx = S_B;
            end else if (is_operator(w_event_key)) begin
              w_op_nx = key_to_op(w_event_key);
            end
          end
        end
        S_B: begin
          if (w_key_ok && !w_locked) begin
            if (is_digit(w_event_key)) begin
              if (r_cnt_b < C_MAXD) begin
                w_opb_nx   = (r_opb << 4) | w_digit;
                w_cnt_b_nx = r_cnt_b + C_DCW'(1);
              end else begin
`ifdef ENTRY_OVERFLOW_ERR_EN
                w_err_nx = 1'b1;
`endif
              end
            end else if (w_event_key == C_KEY_EQ) begin
              w_state_nx = S_START;
            end
          end
        end
        S_START: begin
          if (alu.alu_ready)
            w_state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (alu.alu_done) begin
            w_display_nx = alu.alu_result;
            w_state_nx   = S_SHOW;
          end
        end
        S_SHOW: begin
          if (w_key_ok && !w_locked) begin
            if (is_digit(w_event_key)) begin
              w_opa_nx   = w_digit;
              w_opb_nx   = '0;
              w_cnt_a_nx = C_DCW'(1);
              w_cnt_b_nx = '0;
              w_state_nx = S_A;
            end else if (is_operator(w_event_key)) begin
              // The shown result becomes the left operand of a chained op.
              w_opa_nx   = r_display;
              w_cnt_a_nx = C_MAXD;
              w_op_nx    = key_to_op(w_event_key);
              w_state_nx = S_OP;
            end
          end
        end
        default: w_state_nx = S_A;
      endcase

      case (w_state_nx)
        S_A, S_OP: w_display_nx = w_opa_nx;
        S_B:       w_display_nx = w_opb_nx;
        default:   ;
      endcase
    end
  end

  assign alu.operand_a = r_opa;
  assign alu.operand_b = r_opb;
  assign alu.op        = r_op;
  assign alu.alu_start = (r_state == S_START);
  assign busy          = (r_state == S_START) || (r_state == S_WAIT);
  assign display       = r_display;
`ifdef ENTRY_OVERFLOW_ERR_EN
  assign error         = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_entry_controller.sv
// ============================================================================
// Module : tb_entry_controller
// Brief  : Directed self-checking bench for entry_controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_entry_controller;

  localparam int C_MAXD = 4;
  localparam int C_W    = 4 * C_MAXD;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           iteration_tick = 1'b0;
  logic           valid_iteration = 1'b0;
  logic [3:0]     key = 4'h0;
  logic [C_W-1:0] display;
  logic           busy;
`ifdef ENTRY_OVERFLOW_ERR_EN
  logic           error;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  entry_controller_if #(.MAX_DIGITS(C_MAXD)) alu ();

  entry_controller #(
    .DEBOUNCE_SCANS(3),
    .MAX_DIGITS    (C_MAXD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iteration_tick  (iteration_tick),
    .valid_iteration (valid_iteration),
    .key             (key),
    .alu             (alu.master),
    .display         (display),
`ifdef ENTRY_OVERFLOW_ERR_EN
    .error           (error),
`endif
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic scan(input logic v, input logic [3:0] k);
    valid_iteration = v;
    key             = k;
    iteration_tick  = 1'b1;
    cycles(1);
    iteration_tick  = 1'b0;
    cycles(3);
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    for (int i = 0; i < hold; i++) scan(1'b1, k);
    for (int i = 0; i < 3; i++) scan(1'b0, k);
  endtask

  task automatic pulse_ready();
    alu.alu_ready = 1'b1;
    cycles(1);
    alu.alu_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic [C_W-1:0] res);
    alu.alu_result = res;
    alu.alu_done   = 1'b1;
    cycles(1);
    alu.alu_done   = 1'b0;
    cycles(1);
  endtask

  initial begin
    alu.alu_ready  = 1'b0;
    alu.alu_done   = 1'b0;
    alu.alu_result = '0;
    cycles(3);
    reset = 1'b0;
    cycles(1);

    check("rst_display", 32'(display), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(alu.alu_start), 32'h0);
    check("rst_op", 32'(alu.op), 32'h0);
    check("rst_opa", 32'(alu.operand_a), 32'h0);
`ifdef ENTRY_OVERFLOW_ERR_EN
    check("rst_error", 32'(error), 32'h0);
`endif

    // Held key 5 for six scans yields exactly one digit.
    press(4'h5, 6);
    check("hold5_opa", 32'(alu.operand_a), 32'h0005);
    check("hold5_disp", 32'(display), 32'h0005);
    press(4'hF, 3);
    check("clr_opa", 32'(alu.operand_a), 32'h0);

    press(4'h1, 3); press(4'h2, 3); press(4'hA, 3); press(4'h3, 3);
    check("b_disp", 32'(display), 32'h0003);
    press(4'hE, 3);
    check("start_hi", 32'(alu.alu_start), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    check("start_opa", 32'(alu.operand_a), 32'h0012);
    check("start_opb", 32'(alu.operand_b), 32'h0003);
    check("start_op", 32'(alu.op), 32'h0);
    check("start_disp", 32'(display), 32'h0003);
    pulse_ready();
    check("wait_start_lo", 32'(alu.alu_start), 32'h0);
    check("wait_busy", 32'(busy), 32'h1);

    pulse_done(16'h0015);
    check("show_disp", 32'(display), 32'h0015);
    check("show_busy", 32'(busy), 32'h0);

    press(4'hB, 3); press(4'h2, 3); press(4'hE, 3);
    check("chain_opa", 32'(alu.operand_a), 32'h0015);
    check("chain_opb", 32'(alu.operand_b), 32'h0002);
    check("chain_op", 32'(alu.op), 32'h1);
    check("chain_start", 32'(alu.alu_start), 32'h1);
    pulse_ready();

    // Clear while waiting: late result must be discarded.
    press(4'hF, 3);
    check("wclr_busy", 32'(busy), 32'h0);
    check("wclr_disp", 32'(display), 32'h0);
    pulse_done(16'h0099);
    check("late_disp", 32'(display), 32'h0);
    check("late_busy", 32'(busy), 32'h0);
    press(4'h4, 3);
    check("late_in_a", 32'(alu.operand_a), 32'h0004);
    press(4'hF, 3);

    press(4'h1, 3); press(4'h2, 3); press(4'h3, 3); press(4'h4, 3); press(4'h5, 3);
    check("ovf_opa", 32'(alu.operand_a), 32'h1234);
`ifdef ENTRY_OVERFLOW_ERR_EN
    check("ovf_error", 32'(error), 32'h1);
    press(4'hA, 3);
    check("ovf_locked_op", 32'(alu.op), 32'h0);
`endif
    press(4'h6, 3);
    check("ovf_opa2", 32'(alu.operand_a), 32'h1234);
    press(4'hF, 3);
`ifdef ENTRY_OVERFLOW_ERR_EN
    check("ovf_clr_error", 32'(error), 32'h0);
`endif

    // 7 bounces to 8 before debounce completes.
    scan(1'b1, 4'h7); scan(1'b1, 4'h7);
    press(4'h8, 3);
    check("glitch_opa", 32'(alu.operand_a), 32'h0008);
    press(4'hF, 3);

    // Operator overwrite in S_OP, then digit after result starts fresh.
    press(4'h9, 3); press(4'hA, 3); press(4'hC, 3);
    check("op_overwrite", 32'(alu.op), 32'h2);
    press(4'h2, 3); press(4'hE, 3);
    pulse_ready();
    pulse_done(16'h0018);
    check("show2_disp", 32'(display), 32'h0018);
    press(4'h7, 3);
    check("show_digit_opa", 32'(alu.operand_a), 32'h0007);
    check("show_digit_opb", 32'(alu.operand_b), 32'h0);
    check("show_digit_disp", 32'(display), 32'h0007);

    // Reset mid-operation.
    press(4'hA, 3); press(4'h1, 3); press(4'hE, 3);
    check("pre_rst_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_start", 32'(alu.alu_start), 32'h0);
    check("mid_rst_disp", 32'(display), 32'h0);
    check("mid_rst_opa", 32'(alu.operand_a), 32'h0);
    press(4'h3, 3);
    check("post_rst_opa", 32'(alu.operand_a), 32'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
